// File: rtl/instr_fetch.sv
// instr_fetch: fetch stage ahead of the Control unit.
// Owns the PC, issues word reads to instruction memory, latches the returned
// word into the IR and slices it into the fields used by Control, the
// register file and the ALU source mux. Copes with variable-latency memory,
// downstream stall and branch/jump redirect (in-flight data is discarded).
// Optional feature: define FETCH_COUNT_EN to add a saturating 32-bit count
// of instructions latched into the IR (output fetch_count).
module instr_fetch #(
  parameter int                ADDR_W   = 16,
  parameter int                INSTR_W  = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               CLK,
  input  logic               reset,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_valid,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic               valid_out,
  output logic [ADDR_W-1:0]  pc_out,
  output logic [INSTR_W-1:0] instr,
  output logic [2:0]         opcode,
  output logic [2:0]         rd,
  output logic [2:0]         rs,
  output logic [2:0]         rt,
  output logic [3:0]         func,
`ifdef FETCH_COUNT_EN
  output logic [31:0]        fetch_count,
`endif
  output logic [15:0]        imm
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t              state, state_d;
  logic [ADDR_W-1:0]   pc, pc_d;
  logic [ADDR_W-1:0]   pc_out_q, pc_out_d;
  logic [INSTR_W-1:0]  ir, ir_d;
  logic                valid_q, valid_d;
  logic                drop, drop_d;
  logic                latch;

  // Next-state, request and register-update logic; redirect outranks stall and memory data
  always_comb begin
    state_d  = state;
    pc_d     = pc;
    pc_out_d = pc_out_q;
    ir_d     = ir;
    valid_d  = valid_q;
    drop_d   = drop;
    latch    = 1'b0;
    imem_req = 1'b0;
    case (state)
      FETCH: begin
        imem_req = !branch_taken;
        state_d  = WAIT;
        if (branch_taken) begin
          pc_d    = branch_target;
          valid_d = 1'b0;
        end
      end
      WAIT: begin
        imem_req = 1'b1;
        if (branch_taken) begin
          pc_d    = branch_target;
          valid_d = 1'b0;
          if (imem_valid) begin
            drop_d  = 1'b0;
            state_d = FETCH;
          end else begin
            drop_d  = 1'b1;
          end
        end else if (imem_valid) begin
          if (drop) begin
            drop_d  = 1'b0;
            state_d = FETCH;
          end else begin
            latch    = 1'b1;
            ir_d     = imem_rdata;
            pc_out_d = pc;
            pc_d     = pc + 1'b1;
            valid_d  = 1'b1;
            state_d  = HOLD;
          end
        end
      end
      HOLD: begin
        if (branch_taken) begin
          pc_d    = branch_target;
          valid_d = 1'b0;
          state_d = FETCH;
        end else if (valid_q && !stall) begin
          valid_d = 1'b0;
          state_d = FETCH;
        end
      end
      default: begin
        state_d = FETCH;
      end
    endcase
    if (reset) begin
      imem_req = 1'b0;
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (reset) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      pc_out_q <= '0;
      ir       <= '0;
      valid_q  <= 1'b0;
      drop     <= 1'b0;
    end else begin
      state    <= state_d;
      pc       <= pc_d;
      pc_out_q <= pc_out_d;
      ir       <= ir_d;
      valid_q  <= valid_d;
      drop     <= drop_d;
    end
  end

`ifdef FETCH_COUNT_EN
  logic [31:0] count_q;

  // Saturating count of instructions actually latched into the IR
  always_ff @(posedge CLK) begin
    if (reset) begin
      count_q <= '0;
    end else if (latch && (count_q != 32'hFFFF_FFFF)) begin
      count_q <= count_q + 32'd1;
    end
  end

  assign fetch_count = count_q;
`endif

  assign imem_addr = pc;
  assign valid_out = valid_q;
  assign pc_out    = pc_out_q;
  assign instr     = ir;
  assign opcode    = ir[15:13];
  assign rd        = ir[12:10];
  assign rs        = ir[9:7];
  assign rt        = ir[6:4];
  assign func      = ir[3:0];
  assign imm       = {{9{ir[6]}}, ir[6:0]};

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage directly upstream of the Control unit: owns the PC, issues word reads to instruction memory, and latches the returned instruction into an instruction register (IR).
- Splits the IR into opcode/func (consumed by Control) and register/immediate fields (consumed by the register file and ALU source mux).
- Handles variable-latency memory, downstream stall, and branch/jump redirect with discard of in-flight fetches.

Parameters:
ADDR_W, 16, PC / instruction memory address width (word addressed)
INSTR_W, 16, instruction width; field map below assumes 16
RESET_PC, 0, PC value loaded on reset

Ports:
CLK  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
imem_req  out  1  read request to instruction memory
imem_addr  out  ADDR_W  word address of request (equals PC)
imem_rdata  in  INSTR_W  returned instruction
imem_valid  in  1  imem_rdata valid this cycle (1 or more cycles after request)
stall  in  1  downstream cannot accept a new instruction
branch_taken  in  1  one-cycle redirect pulse (branch/jump resolved)
branch_target  in  ADDR_W  new PC when branch_taken=1
valid_out  out  1  IR holds an unconsumed instruction
pc_out  out  ADDR_W  address of instruction in IR
instr  out  INSTR_W  raw IR
opcode  out  3  IR[15:13]
rd  out  3  IR[12:10]
rs  out  3  IR[9:7]
rt  out  3  IR[6:4]
func  out  4  IR[3:0]
imm  out  16  IR[6:0] sign-extended to 16 bits

Behaviour:
- Reset (synchronous, highest priority): PC=RESET_PC, state=FETCH, IR=0, valid_out=0, pc_out=0, imem_req=0, drop flag=0. Therefore opcode=0, func=0, all decoded fields 0, imm=0.
- All field outputs are combinational slices of IR; IR changes only on a successful latch.
- FETCH: imem_req=1, imem_addr=PC. Next state WAIT.
- WAIT: imem_req held 1 and imem_addr held at PC until imem_valid.
  - On imem_valid with drop=0: IR<=imem_rdata, pc_out<=PC, PC<=PC+1 (wraps modulo 2^ADDR_W), valid_out<=1, state->HOLD.
  - On imem_valid with drop=1: data discarded, drop<=0, state->FETCH.
- HOLD: imem_req=0. An instruction is consumed on any cycle with valid_out=1 and stall=0.
  - On consume: valid_out<=0, state->FETCH.
  - While stall=1: IR, pc_out and valid_out are held stable.
- Minimum issue rate: request cycle, response cycle (1-cycle memory), consume cycle gives one instruction per 3 cycles. No prefetch.
- Redirect (branch_taken=1, priority over stall and imem_valid):
  - PC<=branch_target and valid_out<=0 in every state.
  - FETCH: state->WAIT with imem_addr=branch_target; the request issues on the following cycle.
  - WAIT: drop<=1 unless imem_valid is high in the same cycle, in which case that data is discarded and state->FETCH.
  - HOLD: state->FETCH.
- branch_taken and stall together: redirect wins; the stalled IR is invalidated and IR contents are not required to change.
- Reset during WAIT: request dropped immediately. A late imem_valid after reset is ignored, because state is FETCH and only WAIT samples imem_valid.
- imem_valid outside WAIT is ignored.

Optional Feature:
- Macro FETCH_COUNT_EN.
- Defined: adds output fetch_count (32 bits).
  - Resets to 0.
  - Increments by 1 on each IR latch (drop=0 path only).
  - Saturates at 32'hFFFFFFFF.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset with RESET_PC=0, 1-cycle memory returning 16'h2403: first fetch at imem_addr=0; IR latched 2 cycles after reset release; opcode=1, rd=1, rs=0, func=3, imm=16'h0003, valid_out=1, pc_out=0.
- Stall: hold stall=1 for 5 cycles while valid_out=1 -> instr/pc_out/valid_out unchanged and imem_req=0 throughout. Release -> consumed, next imem_addr=1.
- Variable latency: imem_valid asserted 4 cycles after request -> imem_req and imem_addr stay constant for all 4 cycles. Memory returning 16'hFFF0: imm=16'hFFF0, opcode=7, func=0.
- Branch in WAIT: branch_taken with branch_target=16'h0040 while a request to 5 is outstanding -> returned data discarded (valid_out stays 0). Next request has imem_addr=16'h0040; latched pc_out=16'h0040.
- Wrap and reset mid-operation:
  - PC=16'hFFFF fetched -> next imem_addr=0.
  - reset asserted during WAIT followed by a late imem_valid -> IR stays 0, valid_out=0, next request at RESET_PC.
- With FETCH_COUNT_EN defined: 3 fetches, 1 dropped fetch, then 2 more fetches -> fetch_count=5; reset returns it to 0.
